// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, multiplier FSM states and the NZCV flag bundle shared by alu_pipe.
package alu_pkg;
  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_LSL    = 4'b0011;
  localparam logic [3:0] OP_LSR    = 4'b0100;
  localparam logic [3:0] OP_MUL    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_PASSB  = 4'b0111;
  localparam logic [3:0] OP_PASSBM = 4'b1000;
  typedef enum logic {ST_IDLE, ST_MULT} state_e;
  typedef struct packed {logic n; logic z; logic c; logic v;} flags_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per cycle. The product is shown on
// o_prod while o_done, so the last step and the output-register write share one edge.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_hold,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);
  state_e r_state, w_next;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_next;
  logic [CW-1:0] r_cnt;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == ST_IDLE && i_start) w_next = ST_MULT;
    else if (o_done) w_next = ST_IDLE;
  end
  // a held output lets the count run down to 0 and park there with the product in r_acc
  always_comb begin
    o_busy = r_state == ST_MULT;
    o_done = o_busy && r_cnt <= CW'(1) && !i_hold;
    o_prod = r_cnt == CW'(1) ? w_acc_next : r_acc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == ST_IDLE && i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (o_busy && r_cnt != '0) begin
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt - CW'(1);
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with NZCV flags and valid/ready handshake.
// Define ALU_MUL_EN to add the iterative multiplier behind opcode 0101.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             ResetL,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [3:0]       ALUCtrl,
  input  logic [SHW-1:0]   ShAmt,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal,
  output logic             Busy
);
  logic [WIDTH:0] w_add;
  logic [WIDTH-1:0] w_sub, w_res, w_prod, r_bus;
  logic w_c, w_v, w_ill, w_accept, w_start, w_busy, w_done, w_wr, r_valid, r_ill;
  flags_t r_fl;
  assign w_add = {1'b0, BusA} + {1'b0, BusB};
  assign w_sub = BusA - BusB;
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (ALUCtrl)
      OP_AND:    w_res = BusA & BusB;
      OP_OR:     w_res = BusA | BusB;
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = BusA[WIDTH-1] == BusB[WIDTH-1] && w_add[WIDTH-1] != BusA[WIDTH-1];
      end
      OP_LSL:    w_res = BusA << ShAmt;
      OP_LSR:    w_res = BusA >> ShAmt;
      OP_SUB: begin
        w_res = w_sub;
        w_c   = BusA >= BusB;
        w_v   = BusA[WIDTH-1] != BusB[WIDTH-1] && w_sub[WIDTH-1] != BusA[WIDTH-1];
      end
      OP_PASSB:  w_res = BusB << 16;
      OP_PASSBM: w_res = BusB;
      default:   w_ill = 1'b1;
    endcase
  end
  assign InReady  = !w_busy && (!r_valid || OutReady);
  assign w_accept = InValid && InReady;
`ifdef ALU_MUL_EN
  assign w_start = w_accept && ALUCtrl == OP_MUL;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(Clk), .rst_n(ResetL), .i_start(w_start), .i_hold(r_valid && !OutReady),
    .i_a(BusA), .i_b(BusB), .o_busy(w_busy), .o_done(w_done), .o_prod(w_prod)
  );
`else
  assign w_start = 1'b0;
  assign w_busy  = 1'b0;
  assign w_done  = 1'b0;
  assign w_prod  = '0;
`endif
  assign w_wr = (w_accept && !w_start) || w_done;
  always_ff @(posedge Clk or negedge ResetL)
    if (!ResetL) begin
      r_valid <= 1'b0;
      r_bus   <= '0;
      r_fl    <= 4'b0100;
      r_ill   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_bus <= w_done ? w_prod : w_res;
        r_fl  <= w_done ? {w_prod[WIDTH-1], ~|w_prod, 2'b00} : {w_res[WIDTH-1], ~|w_res, w_c, w_v};
        r_ill <= !w_done && w_ill;
      end
      r_valid <= w_wr || (r_valid && !OutReady);
    end
  assign OutValid = r_valid;
  assign BusW     = r_bus;
  assign Negative = r_fl.n;
  assign Zero     = r_fl.z;
  assign Carry    = r_fl.c;
  assign Overflow = r_fl.v;
  assign Illegal  = r_ill;
  assign Busy     = w_busy;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against a behavioural model.
module tb_alu_pipe;
  localparam int W  = 64;
  localparam int SW = $clog2(W);
  typedef struct packed {logic [W-1:0] r; logic n, z, c, v, ill;} exp_t;
  logic Clk = 0, ResetL = 0, InValid = 0, OutReady = 1;
  logic InReady, OutValid, Zero, Negative, Carry, Overflow, Illegal, Busy;
  logic [W-1:0] BusA = '0, BusB = '0, BusW;
  logic [3:0] ALUCtrl = '0;
  logic [SW-1:0] ShAmt = '0;
  int checks = 0, errors = 0;
  exp_t obs;
  assign obs = {BusW, Negative, Zero, Carry, Overflow, Illegal};

  alu_pipe #(.WIDTH(W)) dut (
    .Clk(Clk), .ResetL(ResetL), .InValid(InValid), .InReady(InReady), .BusA(BusA), .BusB(BusB),
    .ALUCtrl(ALUCtrl), .ShAmt(ShAmt), .OutValid(OutValid), .OutReady(OutReady), .BusW(BusW),
    .Zero(Zero), .Negative(Negative), .Carry(Carry), .Overflow(Overflow), .Illegal(Illegal),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [SW-1:0] sh);
    exp_t e;
    logic signed [W+1:0] wide, smax, smin;
    e    = '0;
    smax = $signed({3'b000, {(W-1){1'b1}}});
    smin = -smax - 1;
    case (op)
      4'd0: e.r = a & b;
      4'd1: e.r = a | b;
      4'd2: begin
        e.r  = a + b;
        e.c  = e.r < a;
        wide = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b});
        e.v  = wide > smax || wide < smin;
      end
      4'd3: e.r = a << sh;
      4'd4: e.r = a >> sh;
`ifdef ALU_MUL_EN
      4'd5: e.r = a * b;
`endif
      4'd6: begin
        e.r  = a - b;
        e.c  = a >= b;
        wide = $signed({{2{a[W-1]}}, a}) - $signed({{2{b[W-1]}}, b});
        e.v  = wide > smax || wide < smin;
      end
      4'd7: e.r = b << 16;
      4'd8: e.r = b;
      default: e.ill = 1'b1;
    endcase
    e.n = e.r[W-1];
    e.z = e.r == '0;
    return e;
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
    if (op == 4'd5) op = 4'd2;
`endif
    return op;
  endfunction

  task automatic op1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [SW-1:0] sh, input string name);
    exp_t e;
    e = model(op, a, b, sh);
    ALUCtrl = op; BusA = a; BusB = b; ShAmt = sh; InValid = 1; OutReady = 1;
    @(posedge Clk); #1;
    InValid = 0;
    checks++;
    if (OutValid !== 1'b1 || obs !== e) begin
      errors++;
      $display("FAIL %s: valid=%b BusW=%h nzcvi=%b%b%b%b%b, want valid=1 BusW=%h nzcvi=%b%b%b%b%b",
               name, OutValid, obs.r, obs.n, obs.z, obs.c, obs.v, obs.ill, e.r, e.n, e.z, e.c, e.v, e.ill);
    end
  endtask

  task automatic test_reset();
    ResetL = 0; InValid = 0; OutReady = 1;
    repeat (2) @(posedge Clk);
    #2 ResetL = 1;
    #1;
    checks++;
    if (obs !== exp_t'({{W{1'b0}}, 5'b01000}) || {OutValid, InReady, Busy} !== 3'b010) begin
      errors++;
      $display("FAIL reset: BusW=%h nzcvi=%b%b%b%b%b valid/ready/busy=%b%b%b, want 0 01000 010",
               BusW, Negative, Zero, Carry, Overflow, Illegal, OutValid, InReady, Busy);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ones, maxp;
    ones = '1;
    maxp = ones >> 1;
    @(posedge Clk); #1;
    op1(4'b0010, 64'd5, 64'd3, '0, "add_5_3");
    op1(4'b0110, 64'h10, 64'h10, '0, "sub_equal");
    op1(4'b0110, 64'd0, 64'd1, '0, "sub_borrow");
    op1(4'b0010, maxp, 64'd1, '0, "add_overflow");
    op1(4'b0010, ones, 64'd1, '0, "add_carry");
    op1(4'b0110, ~maxp, 64'd1, '0, "sub_overflow");
    op1(4'b0111, 64'hABCD, 64'hABCD, '0, "passb");
    op1(4'b1000, 64'd1, ones, '0, "passbm");
    op1(4'b0011, 64'h8000_0001, 64'd0, 6'd63, "lsl_63");
    op1(4'b0100, ones, 64'd0, 6'd4, "lsr_4");
    op1(4'b1111, ones, ones, '0, "illegal_1111");
`ifndef ALU_MUL_EN
    op1(4'b0101, 64'd12, 64'd13, '0, "mul_disabled");
`endif
  endtask

  task automatic test_stall();
    exp_t e_add, e_or;
    InValid = 0; OutReady = 1;
    @(posedge Clk); #1;
    e_add = model(4'b0010, 64'd100, 64'd23, '0);
    e_or  = model(4'b0001, 64'hF0, 64'h0F, '0);
    OutReady = 0; InValid = 1; ALUCtrl = 4'b0010; BusA = 64'd100; BusB = 64'd23;
    @(posedge Clk); #1;
    checks++;
    if (OutValid !== 1'b1 || obs !== e_add) begin
      errors++;
      $display("FAIL stall_add: valid=%b BusW=%h, want 1 %h", OutValid, BusW, e_add.r);
    end
    ALUCtrl = 4'b0001; BusA = 64'hF0; BusB = 64'h0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (InReady !== 1'b0 || OutValid !== 1'b1 || obs !== e_add) begin
        errors++;
        $display("FAIL stall_hold: ready=%b valid=%b BusW=%h, want 0 1 %h", InReady, OutValid, BusW, e_add.r);
      end
      @(posedge Clk); #1;
    end
    OutReady = 1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: ready=%b, want 1", InReady);
    end
    @(posedge Clk); #1;
    InValid = 0;
    checks++;
    if (OutValid !== 1'b1 || obs !== e_or) begin
      errors++;
      $display("FAIL stall_or: valid=%b BusW=%h, want 1 %h", OutValid, BusW, e_or.r);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] op;
    logic [W-1:0] a, b;
    logic [SW-1:0] sh;
    OutReady = 1;
    for (int i = 0; i < 16; i++) begin
      op = rand_op(); a = {$urandom, $urandom}; b = {$urandom, $urandom}; sh = SW'($urandom);
      e = model(op, a, b, sh);
      ALUCtrl = op; BusA = a; BusB = b; ShAmt = sh; InValid = 1;
      #1;
      checks++;
      if (InReady !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: ready=%b, want 1", i, InReady);
      end
      @(posedge Clk); #1;
      checks++;
      if (OutValid !== 1'b1 || obs !== e) begin
        errors++;
        $display("FAIL b2b[%0d] op=%h: valid=%b BusW=%h nzcvi=%b%b%b%b%b, want %h %b%b%b%b%b", i, op,
                 OutValid, obs.r, obs.n, obs.z, obs.c, obs.v, obs.ill, e.r, e.n, e.z, e.c, e.v, e.ill);
      end
    end
    InValid = 0;
  endtask

  task automatic test_random();
    exp_t q[$];
    logic acc, take;
    InValid = 0; OutReady = 1;
    @(posedge Clk); #1;
    for (int i = 0; i < 400; i++) begin
      InValid = 1'($urandom_range(0, 1));
      OutReady = $urandom_range(0, 3) != 0;
      ALUCtrl = rand_op();
      BusB = {$urandom, $urandom};
      BusA = $urandom_range(0, 3) == 0 ? BusB : {$urandom, $urandom};
      ShAmt = SW'($urandom);
      #1;
      checks++;
      if (OutValid !== (q.size() != 0) || InReady !== (q.size() == 0 || OutReady)) begin
        errors++;
        $display("FAIL rand_hs[%0d]: valid=%b ready=%b, want %b %b", i, OutValid, InReady,
                 q.size() != 0, q.size() == 0 || OutReady);
      end
      if (q.size() != 0) begin
        checks++;
        if (obs !== q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: BusW=%h nzcvi=%b%b%b%b%b, want %h %b%b%b%b%b", i, obs.r, obs.n,
                   obs.z, obs.c, obs.v, obs.ill, q[0].r, q[0].n, q[0].z, q[0].c, q[0].v, q[0].ill);
        end
      end
      acc  = InValid && (q.size() == 0 || OutReady);
      take = q.size() != 0 && OutReady;
      if (take) void'(q.pop_front());
      if (acc) q.push_back(model(ALUCtrl, BusA, BusB, ShAmt));
      @(posedge Clk); #1;
    end
    InValid = 0; OutReady = 1;
    @(posedge Clk); #1;
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    exp_t e;
    int busy_cnt, cyc;
    e = model(4'b0101, 64'd12, 64'd13, '0);
    OutReady = 1; ALUCtrl = 4'b0101; BusA = 64'd12; BusB = 64'd13; InValid = 1;
    @(posedge Clk); #1;
    InValid = 0;
    busy_cnt = 0; cyc = 0;
    while (OutValid !== 1'b1 && cyc < 200) begin
      if (Busy === 1'b1 && InReady === 1'b0) busy_cnt++;
      @(posedge Clk); #1;
      cyc++;
    end
    checks++;
    if (busy_cnt != W || cyc != W || obs !== e) begin
      errors++;
      $display("FAIL mul_12x13: busy=%0d edges=%0d BusW=%h, want %0d %0d %h", busy_cnt, cyc, BusW, W, W, e.r);
    end
    ALUCtrl = 4'b0101; BusA = {$urandom, $urandom}; BusB = {$urandom, $urandom}; InValid = 1;
    @(posedge Clk); #1;
    InValid = 0;
    repeat (19) @(posedge Clk);
    #1 ResetL = 0;
    #2 ResetL = 1;
    #1;
    checks++;
    if ({OutValid, InReady, Busy} !== 3'b010) begin
      errors++;
      $display("FAIL mul_reset: valid/ready/busy=%b%b%b, want 010", OutValid, InReady, Busy);
    end
    cyc = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge Clk); #1;
      if (OutValid !== 1'b0) cyc++;
    end
    checks++;
    if (cyc != 0) begin
      errors++;
      $display("FAIL mul_reset_discard: OutValid high %0d cycles, want 0", cyc);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_random();
`ifdef ALU_MUL_EN
    test_mul();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
